// File: rtl/fa_pkg.sv
// Shared types and constants for the full-adder exhaustive checker.
package fa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } fa_state_e;

    localparam int         NUM_VECTORS = 8;
    localparam logic [2:0] LAST_IDX    = 3'd7;

endpackage

// File: rtl/fa_ref_model.sv
// Golden full-adder: 2-bit {carry,sum} of three 1-bit operands.
module fa_ref_model (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [1:0] result
);

    assign result = {1'b0, a} + {1'b0, b} + {1'b0, c};

endmodule

// File: rtl/fa_checker.sv
// Sweeps all 8 input vectors through an external full adder, waits for the
// outputs to settle, and scores each vector against the reference model.
module fa_checker
    import fa_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic       sum_in,
    input  logic       carry_in,
    output logic       a_out,
    output logic       b_out,
    output logic       cin_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       pass_out,
    output logic [3:0] err_count_out,
    output logic       fail_valid_out,
    output logic [2:0] fail_vec_out
);

    fa_state_e  state;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic [1:0] exp_val;
    logic       mismatch;
    logic [3:0] err_nxt;

    fa_ref_model u_ref (
        .a      (idx[2]),
        .b      (idx[1]),
        .c      (idx[0]),
        .result (exp_val)
    );

    // Stimulus comes straight from idx, which only changes on CHECK->APPLY,
    // so the vector is stable from APPLY through CHECK.
    assign {a_out, b_out, cin_out} = idx;

    assign mismatch = ({carry_in, sum_in} != exp_val);
    assign err_nxt  = (err_count_out == 4'(NUM_VECTORS)) ? err_count_out
                                                         : err_count_out + 4'd1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            pass_out       <= 1'b0;
            err_count_out  <= '0;
            fail_valid_out <= 1'b0;
            fail_vec_out   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_in) begin
                        idx            <= '0;
                        err_count_out  <= '0;
                        fail_valid_out <= 1'b0;
                        fail_vec_out   <= '0;
                        busy_out       <= 1'b1;
                        done_out       <= 1'b0;
                        pass_out       <= 1'b0;
                        state          <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    settle_cnt <= 4'(SETTLE_CYCLES);
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1)
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_count_out <= err_nxt;
                        if (!fail_valid_out) begin
                            fail_valid_out <= 1'b1;
                            fail_vec_out   <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        // Fold this cycle's compare into pass since err_count lags a cycle.
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        pass_out <= !mismatch && (err_count_out == 4'd0);
                        state    <= ST_DONE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= ST_APPLY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_checker.sv
// Directed bench: full-adder model with injectable faults around two checkers.
module tb_fa_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic [1:0] fault;

    logic       a, b, cin, busy, done, pass, fv;
    logic [3:0] err;
    logic [2:0] fvec;
    logic       fa_sum, fa_carry;

    logic       a1, b1, cin1, busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [2:0] fvec1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Full adder under test: fault 1 = sum stuck at 0, fault 2 = carry inverted.
    always_comb begin
        fa_sum   = a ^ b ^ cin;
        fa_carry = (a & b) | (a & cin) | (b & cin);
        if (fault == 2'd1) fa_sum = 1'b0;
        if (fault == 2'd2) fa_carry = ~fa_carry;
    end

    fa_checker u_dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .sum_in(fa_sum), .carry_in(fa_carry),
        .a_out(a), .b_out(b), .cin_out(cin),
        .busy_out(busy), .done_out(done), .pass_out(pass),
        .err_count_out(err), .fail_valid_out(fv), .fail_vec_out(fvec)
    );

    fa_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start1),
        .sum_in(a1 ^ b1 ^ cin1), .carry_in((a1 & b1) | (a1 & cin1) | (b1 & cin1)),
        .a_out(a1), .b_out(b1), .cin_out(cin1),
        .busy_out(busy1), .done_out(done1), .pass_out(pass1),
        .err_count_out(err1), .fail_valid_out(fv1), .fail_vec_out(fvec1)
    );

    // Start is accepted on the edge between the two negedges; returns at the
    // negedge right after the accepting edge. Optionally re-pulses start at
    // cycle inject_at. cycles = edges after acceptance until done is seen.
    task automatic run_sweep(input int inject_at, output int cycles);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            start = (cycles == inject_at);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; fault = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a, b, cin, busy, done, pass, err, fv, fvec} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0", {a, b, cin, busy, done, pass, err, fv, fvec});
        end
        checks++;
        if ({a1, b1, cin1, busy1, done1, pass1, err1, fv1, fvec1} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs_s1 got=%h expected=0", {a1, b1, cin1, busy1, done1, pass1, err1, fv1, fvec1});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b done=%b expected busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_correct;
        int cyc;
        fault = 2'd0;
        run_sweep(-1, cyc);
        checks++;
        if (cyc != 32) begin failures++; $display("FAIL correct_latency got=%0d expected=32", cyc); end
        checks++;
        if (pass !== 1'b1 || err !== 4'd0 || fv !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL correct_result pass=%b err=%0d fv=%b busy=%b expected pass=1 err=0 fv=0 busy=0", pass, err, fv, busy);
        end
    endtask

    task automatic test_stuck_sum;
        int cyc;
        fault = 2'd1;
        run_sweep(-1, cyc);
        checks++;
        if (cyc != 32) begin failures++; $display("FAIL stuck_latency got=%0d expected=32", cyc); end
        checks++;
        if (err !== 4'd4 || fvec !== 3'b001 || pass !== 1'b0 || fv !== 1'b1) begin
            failures++;
            $display("FAIL stuck_result err=%0d fvec=%b pass=%b fv=%b expected err=4 fvec=001 pass=0 fv=1", err, fvec, pass, fv);
        end
    endtask

    task automatic test_carry_inv;
        int cyc;
        fault = 2'd2;
        run_sweep(-1, cyc);
        checks++;
        if (err !== 4'd8 || fvec !== 3'b000 || pass !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL carry_inv_result err=%0d fvec=%b pass=%b done=%b expected err=8 fvec=000 pass=0 done=1", err, fvec, pass, done);
        end
    endtask

    // A new start from DONE must clear previous results immediately.
    task automatic test_back_to_back;
        int cyc;
        fault = 2'd0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || err !== 4'd0 || fv !== 1'b0 || fvec !== 3'd0) begin
            failures++;
            $display("FAIL restart_clear done=%b busy=%b err=%0d fv=%b fvec=%b expected 0 1 0 0 000", done, busy, err, fv, fvec);
        end
        cyc = 0;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc != 32 || pass !== 1'b1) begin
            failures++;
            $display("FAIL restart_sweep cycles=%0d pass=%b expected 32 1", cyc, pass);
        end
    endtask

    // Re-pulse at cycle 13 lands on the edge where vector 3 sits in SETTLE.
    task automatic test_start_ignored;
        int cyc;
        fault = 2'd0;
        run_sweep(13, cyc);
        checks++;
        if (cyc != 32 || pass !== 1'b1 || err !== 4'd0) begin
            failures++;
            $display("FAIL start_ignored cycles=%0d pass=%b err=%0d expected 32 1 0", cyc, pass, err);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        fault = 2'd1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err !== 4'd1 || {a, b, cin} !== 3'b010) begin
            failures++;
            $display("FAIL pre_reset_state busy=%b err=%0d vec=%b expected 1 1 010", busy, err, {a, b, cin});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({a, b, cin, busy, done, pass, err, fv, fvec} !== 15'd0) begin
            failures++;
            $display("FAIL async_reset got=%h expected=0", {a, b, cin, busy, done, pass, err, fv, fvec});
        end
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || {a, b, cin} !== 3'd0) begin
            failures++;
            $display("FAIL post_reset_idle busy=%b vec=%b expected 0 000", busy, {a, b, cin});
        end
        fault = 2'd0;
        run_sweep(-1, cyc);
        checks++;
        if (cyc != 32 || pass !== 1'b1 || err !== 4'd0 || fv !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_sweep cycles=%0d pass=%b err=%0d fv=%b expected 32 1 0 0", cyc, pass, err, fv);
        end
    endtask

    // With one settle cycle, vector k is presented for edges 3k..3k+2.
    task automatic test_settle1;
        int j;
        logic [2:0] exp_vec;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        j = 0;
        while (!done1 && j < 200) begin
            if (j < 24) begin
                exp_vec = 3'(j / 3);
                checks++;
                if ({a1, b1, cin1} !== exp_vec) begin
                    failures++;
                    $display("FAIL s1_stimulus cycle=%0d got=%b expected=%b", j, {a1, b1, cin1}, exp_vec);
                end
            end
            @(negedge clk);
            j++;
        end
        checks++;
        if (j != 24 || pass1 !== 1'b1 || err1 !== 4'd0) begin
            failures++;
            $display("FAIL s1_sweep cycles=%0d pass=%b err=%0d expected 24 1 0", j, pass1, err1);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck_sum();
        test_carry_inv();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_settle1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
